// File: rtl/ram_memory_controller_if.sv
// Request/complete bus between the cache system's RAM master port and the memory model.
interface ram_memory_controller_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     readEnabled;
    logic                     writeEnabled;
    logic [DATA_WIDTH-1:0]    dataOut;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     functionComplete;

    modport master (
        output address, readEnabled, writeEnabled, dataOut,
        input  dataIn, functionComplete
    );

    modport slave (
        input  address, readEnabled, writeEnabled, dataOut,
        output dataIn, functionComplete
    );
endinterface

// File: rtl/ram_memory_controller.sv
// Word-array main memory serving one held request at a time after a fixed
// read/write latency, with saturating completed-access counters.
module ram_memory_controller #(
    parameter int ADDRESS_WIDTH        = 16,
    parameter int DATA_WIDTH           = 16,
    parameter int MEMORY_ADDRESS_WIDTH = 8,
    parameter int READ_DELAY           = 4,
    parameter int WRITE_DELAY          = 6,
    parameter int COUNTER_WIDTH        = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    ram_memory_controller_if.slave   bus,
    output logic [COUNTER_WIDTH-1:0] readCount,
    output logic [COUNTER_WIDTH-1:0] writeCount
);
    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int DCW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int DEPTH     = 2 ** MEMORY_ADDRESS_WIDTH;

    generate
        if (READ_DELAY < 1 || WRITE_DELAY < 1) begin : g_bad_delay
            $error("ram_memory_controller: READ_DELAY and WRITE_DELAY must be >= 1");
        end
        if (MEMORY_ADDRESS_WIDTH > ADDRESS_WIDTH) begin : g_bad_width
            $error("ram_memory_controller: MEMORY_ADDRESS_WIDTH exceeds ADDRESS_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                          state_q, state_d;
    logic [DCW-1:0]                  delay_q, delay_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
    logic                            is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0]           data_in_q, data_in_d;
    logic [COUNTER_WIDTH-1:0]        rd_cnt_q, rd_cnt_d;
    logic [COUNTER_WIDTH-1:0]        wr_cnt_q, wr_cnt_d;
    logic                            mem_we;
    logic                            req;

    assign req = bus.readEnabled | bus.writeEnabled;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        data_in_d  = data_in_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = bus.address[MEMORY_ADDRESS_WIDTH-1:0];
                    wdata_d    = bus.dataOut;
                    is_write_d = bus.writeEnabled;
                    delay_d    = bus.writeEnabled ? DCW'(WRITE_DELAY - 1) : DCW'(READ_DELAY - 1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // A dropped request wins over completion: nothing is committed.
                if (!req) begin
                    state_d = IDLE;
                end else if (delay_q == '0) begin
                    state_d = DONE;
                    if (is_write_q) begin
                        mem_we    = 1'b1;
                        data_in_d = wdata_q;
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
                    end else begin
                        data_in_d = mem[addr_q];
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            DONE: begin
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            delay_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            data_in_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            data_in_q  <= data_in_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Storage is never reset; mem_we depends on state_q, which reset forces to IDLE.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.dataIn           = data_in_q;
    assign bus.functionComplete = (state_q == DONE) && req;
    assign readCount            = rd_cnt_q;
    assign writeCount           = wr_cnt_q;
endmodule

// File: tb/tb_ram_memory_controller.sv
// Randomised bench for ram_memory_controller against an associative-array memory model.
module tb_ram_memory_controller;
    localparam int RD = 4;
    localparam int WD = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [15:0] read_count, write_count;
    logic [1:0]  sat_read_count, sat_write_count;

    always #5 clock = ~clock;

    ram_memory_controller_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) m_if ();
    ram_memory_controller_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) s_if ();

    ram_memory_controller #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEMORY_ADDRESS_WIDTH(8),
        .READ_DELAY(RD), .WRITE_DELAY(WD), .COUNTER_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .bus(m_if.slave),
        .readCount(read_count), .writeCount(write_count)
    );

    ram_memory_controller #(
        .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEMORY_ADDRESS_WIDTH(8),
        .READ_DELAY(RD), .WRITE_DELAY(WD), .COUNTER_WIDTH(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .bus(s_if.slave),
        .readCount(sat_read_count), .writeCount(sat_write_count)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] model_mem [int];
    int exp_rd = 0;
    int exp_wr = 0;

    // Drives one access on the main bus, scrambles address/data after acceptance,
    // waits (bounded) for completion, then drops the request.
    task automatic m_access(input bit we, input bit re, input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] got, output int lat, output logic fc_drop);
        m_if.address      = a;
        m_if.dataOut      = d;
        m_if.writeEnabled = we;
        m_if.readEnabled  = re;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            m_if.address = 16'($urandom);
            m_if.dataOut = 16'($urandom);
        end while (m_if.functionComplete !== 1'b1 && lat < 40);
        got = m_if.dataIn;
        m_if.writeEnabled = 1'b0;
        m_if.readEnabled  = 1'b0;
        #1 fc_drop = m_if.functionComplete;
        @(negedge clock);
    endtask

    task automatic test_reset;
        m_if.address = '0; m_if.dataOut = '0; m_if.readEnabled = 0; m_if.writeEnabled = 0;
        s_if.address = '0; s_if.dataOut = '0; s_if.readEnabled = 0; s_if.writeEnabled = 0;
        repeat (3) @(negedge clock);
        checks++;
        if (m_if.dataIn !== 16'h0 || m_if.functionComplete !== 1'b0 || read_count !== 16'h0 || write_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: dataIn=%h fc=%b rd=%0d wr=%0d, required 0 0 0 0",
                     m_if.dataIn, m_if.functionComplete, read_count, write_count);
        end
        reset = 1'b1;
        @(negedge clock);
        $display("reset released");
    endtask

    task automatic test_write_read;
        logic [15:0] got; int lat; logic fcd;
        m_access(1, 0, 16'h0012, 16'hBEEF, got, lat, fcd);
        model_mem[8'h12] = 16'hBEEF; exp_wr++;
        checks++;
        if (lat != WD + 1 || got !== 16'hBEEF || fcd !== 1'b0) begin
            failures++;
            $display("FAIL write_basic: lat=%0d data=%h fc_drop=%b, required %0d BEEF 0", lat, got, fcd, WD + 1);
        end
        m_access(0, 1, 16'h0012, 16'h0000, got, lat, fcd);
        exp_rd++;
        checks++;
        if (lat != RD + 1 || got !== 16'hBEEF || read_count !== 16'(exp_rd) || write_count !== 16'(exp_wr)) begin
            failures++;
            $display("FAIL read_basic: lat=%0d data=%h rd=%0d wr=%0d, required %0d BEEF %0d %0d",
                     lat, got, read_count, write_count, RD + 1, exp_rd, exp_wr);
        end
        $display("write/read 0x0012 lat=%0d data=%h", lat, got);
    endtask

    task automatic test_both_enables;
        logic [15:0] got; int lat; logic fcd;
        m_access(1, 1, 16'h0003, 16'h1234, got, lat, fcd);
        model_mem[8'h03] = 16'h1234; exp_wr++;
        checks++;
        if (lat != WD + 1 || got !== 16'h1234 || write_count !== 16'(exp_wr) || read_count !== 16'(exp_rd)) begin
            failures++;
            $display("FAIL both_enables: lat=%0d data=%h rd=%0d wr=%0d, required %0d 1234 %0d %0d",
                     lat, got, read_count, write_count, WD + 1, exp_rd, exp_wr);
        end
        m_access(0, 1, 16'h0003, 16'h0000, got, lat, fcd);
        exp_rd++;
        checks++;
        if (got !== 16'h1234) begin
            failures++;
            $display("FAIL both_readback: data=%h, required 1234", got);
        end
        $display("both enables addr 0x0003 readback=%h", got);
    endtask

    task automatic test_abort;
        logic [15:0] got; int lat; logic fcd; bit saw_fc;
        m_access(1, 0, 16'h0005, 16'h0001, got, lat, fcd);
        model_mem[8'h05] = 16'h0001; exp_wr++;
        m_if.address = 16'h0005; m_if.dataOut = 16'hFFFF; m_if.writeEnabled = 1'b1;
        saw_fc = 0;
        repeat (3) begin
            @(negedge clock);
            if (m_if.functionComplete !== 1'b0) saw_fc = 1;
        end
        m_if.writeEnabled = 1'b0;
        repeat (WD + 2) begin
            @(negedge clock);
            if (m_if.functionComplete !== 1'b0) saw_fc = 1;
        end
        checks++;
        if (saw_fc || write_count !== 16'(exp_wr)) begin
            failures++;
            $display("FAIL abort_no_complete: saw_fc=%b wr=%0d, required 0 %0d", saw_fc, write_count, exp_wr);
        end
        m_access(0, 1, 16'h0005, 16'h0000, got, lat, fcd);
        exp_rd++;
        checks++;
        if (got !== 16'h0001) begin
            failures++;
            $display("FAIL abort_no_commit: data=%h, required 0001", got);
        end
        $display("abort at 0x0005 readback=%h", got);
    endtask

    task automatic test_alias;
        logic [15:0] got; int lat; logic fcd;
        m_access(1, 0, 16'h0107, 16'hAAAA, got, lat, fcd);
        model_mem[8'h07] = 16'hAAAA; exp_wr++;
        m_access(0, 1, 16'h0007, 16'h0000, got, lat, fcd);
        exp_rd++;
        checks++;
        if (got !== 16'hAAAA) begin
            failures++;
            $display("FAIL alias: data=%h, required AAAA", got);
        end
        $display("alias 0x0107 -> 0x0007 data=%h", got);
    endtask

    task automatic test_hold;
        logic [15:0] d; int lat; bit bad;
        d = 16'($urandom);
        m_if.address = 16'h0042; m_if.dataOut = d; m_if.writeEnabled = 1'b1;
        lat = 0;
        do begin @(negedge clock); lat++; end while (m_if.functionComplete !== 1'b1 && lat < 40);
        model_mem[8'h42] = d; exp_wr++;
        bad = (lat != WD + 1);
        repeat (10) begin
            @(negedge clock);
            if (m_if.functionComplete !== 1'b1 || m_if.dataIn !== d) bad = 1;
        end
        checks++;
        if (bad || write_count !== 16'(exp_wr)) begin
            failures++;
            $display("FAIL hold_done: lat=%0d fc=%b data=%h wr=%0d, required %0d 1 %h %0d",
                     lat, m_if.functionComplete, m_if.dataIn, write_count, WD + 1, d, exp_wr);
        end
        m_if.writeEnabled = 1'b0;
        #1;
        checks++;
        if (m_if.functionComplete !== 1'b0) begin
            failures++;
            $display("FAIL hold_drop: fc=%b, required 0", m_if.functionComplete);
        end
        @(negedge clock);
        $display("hold 10 cycles in DONE data=%h", d);
    endtask

    task automatic test_random;
        logic [15:0] got, a, d, expd; int lat; logic fcd; bit we, re; int idx;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            d = 16'($urandom);
            idx = int'(a[7:0]);
            we = 1'($urandom);
            re = 1'($urandom);
            if (!we && !re) re = 1;
            if (!we && !model_mem.exists(idx)) we = 1;
            m_access(we, re, a, d, got, lat, fcd);
            if (we) begin
                model_mem[idx] = d; exp_wr++;
            end else begin
                exp_rd++;
            end
            expd = model_mem[idx];
            checks++;
            if (lat != (we ? WD : RD) + 1 || got !== expd || fcd !== 1'b0 ||
                read_count !== 16'(exp_rd) || write_count !== 16'(exp_wr)) begin
                failures++;
                $display("FAIL random_%0d: lat=%0d data=%h fc_drop=%b rd=%0d wr=%0d, required %0d %h 0 %0d %0d",
                         i, lat, got, fcd, read_count, write_count, (we ? WD : RD) + 1, expd, exp_rd, exp_wr);
            end
            $display("rand %0d we=%b re=%b addr=%h data=%h lat=%0d", i, we, re, a, got, lat);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [15:0] got; int lat; logic fcd;
        m_access(1, 0, 16'h0020, 16'h5555, got, lat, fcd);
        model_mem[8'h20] = 16'h5555; exp_wr++;
        m_if.address = 16'h0020; m_if.dataOut = 16'h9999; m_if.writeEnabled = 1'b1;
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (m_if.dataIn !== 16'h0 || m_if.functionComplete !== 1'b0 || read_count !== 16'h0 ||
            write_count !== 16'h0 || sat_read_count !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: dataIn=%h fc=%b rd=%0d wr=%0d, required 0 0 0 0",
                     m_if.dataIn, m_if.functionComplete, read_count, write_count);
        end
        exp_rd = 0; exp_wr = 0;
        m_if.writeEnabled = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        m_access(0, 1, 16'h0020, 16'h0000, got, lat, fcd);
        exp_rd++;
        checks++;
        if (got !== 16'h5555 || lat != RD + 1 || read_count !== 16'(exp_rd)) begin
            failures++;
            $display("FAIL reset_no_commit: data=%h lat=%0d rd=%0d, required 5555 %0d %0d",
                     got, lat, read_count, RD + 1, exp_rd);
        end
        $display("async reset mid-write, readback=%h", got);
    endtask

    task automatic test_saturation;
        int lat; int exp_sat;
        for (int n = 1; n <= 5; n++) begin
            s_if.address = 16'(n); s_if.readEnabled = 1'b1;
            lat = 0;
            do begin @(negedge clock); lat++; end while (s_if.functionComplete !== 1'b1 && lat < 40);
            s_if.readEnabled = 1'b0;
            @(negedge clock);
            exp_sat = (n > 3) ? 3 : n;
            checks++;
            if (lat != RD + 1 || sat_read_count !== 2'(exp_sat) || sat_write_count !== 2'd0) begin
                failures++;
                $display("FAIL saturate_%0d: lat=%0d rd=%0d wr=%0d, required %0d %0d 0",
                         n, lat, sat_read_count, sat_write_count, RD + 1, exp_sat);
            end
            $display("sat read %0d readCount=%0d", n, sat_read_count);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_both_enables;
        test_abort;
        test_alias;
        test_hold;
        test_random;
        test_reset_mid_write;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
